// File: rtl/m_inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word behind a
// single valid/ready output register, tagging each word with its address and a format-error flag.
module m_inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [4:0]  in_opcode5,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [6:0]         op;
    logic [31:0]        enc_word;
    logic [2:0]         op_class;
    logic               imm_bad;
    logic               enc_err;
    logic signed [31:0] imm_s;
    logic [31:0]        next_addr;
    logic               in_fire;
    logic               out_fire;

    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign op       = {in_opcode5, 2'b11};
    assign imm_s    = $signed(in_imm);

    always_comb begin
        enc_word = '0;
        case (in_type)
            FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, op};
            FMT_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, op};
            FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], op};
            FMT_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], op};
            FMT_U: enc_word = {in_imm[31:12], in_rd, op};
            FMT_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op};
            default: enc_word = '0;
        endcase
    end

    // Format implied by the opcode, used to catch type/opcode disagreement.
    always_comb begin
        op_class = FMT_I;
        case (in_opcode5)
            5'b01100:          op_class = FMT_R;
            5'b01000:          op_class = FMT_S;
            5'b11000:          op_class = FMT_B;
            5'b00101, 5'b01101: op_class = FMT_U;
            5'b11011:          op_class = FMT_J;
            default:           op_class = FMT_I;
        endcase
    end

    always_comb begin
        imm_bad = 1'b0;
        case (in_type)
            FMT_I, FMT_S: imm_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            FMT_B:        imm_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
            FMT_J:        imm_bad = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
            FMT_U:        imm_bad = (in_imm[11:0] != 12'h000);
            default:      imm_bad = 1'b0;
        endcase
    end

    assign enc_err = (in_type > FMT_J) || (in_type != op_class) || imm_bad;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_addr  <= '0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
            next_addr <= BASE_ADDR;
        end else begin
            if (in_fire) begin
                out_inst  <= enc_word;
                out_addr  <= next_addr;
                out_err   <= enc_err;
                next_addr <= next_addr + ADDR_STEP;
            end
            if (in_fire) begin
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            // Errors are counted when delivered, not when accepted.
            if (out_fire && out_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_m_inst_encoder.sv
// Testbench for m_inst_encoder: directed encodings plus a randomized stream
// checked against a field-arithmetic reference model and an expected-word queue.
module tb_m_inst_encoder;

    localparam logic [31:0] BASE = 32'h0;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_type = '0;
    logic [4:0]  in_opcode5 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] modelAddr = BASE;
    int          modelErrCnt = 0;
    int          total = 0;
    int          bad = 0;

    m_inst_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(32'd4)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_opcode5(in_opcode5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 w_clk = ~w_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoding built by shifting fields into their bit positions.
    function automatic logic [31:0] modelEncode(input logic [31:0] t, input logic [31:0] op5,
                                                input logic [31:0] rd, input logic [31:0] rs1,
                                                input logic [31:0] rs2, input logic [31:0] f3,
                                                input logic [31:0] f7, input logic [31:0] imm);
        logic [31:0] op;
        logic [31:0] regs;
        op   = op5 * 4 + 3;
        regs = (rs1 << 15) | (f3 << 12);
        case (t)
            0: return (f7 << 25) | (rs2 << 20) | regs | (rd << 7) | op;
            1: return ((imm & 32'hFFF) << 20) | regs | (rd << 7) | op;
            2: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | regs | ((imm & 32'h1F) << 7) | op;
            3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) | regs
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | op;
            4: return (imm & 32'hFFFFF000) | (rd << 7) | op;
            5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic modelErr(input int t, input logic [4:0] op5, input logic [31:0] imm);
        int cls;
        int s;
        s = $signed(imm);
        case (op5)
            5'b01100: cls = 0;
            5'b01000: cls = 2;
            5'b11000: cls = 3;
            5'b00101, 5'b01101: cls = 4;
            5'b11011: cls = 5;
            default: cls = 1;
        endcase
        if (t > 5 || t != cls) return 1'b1;
        case (t)
            1, 2: return (s < -2048) || (s > 2047);
            3: return (s < -4096) || (s > 4094) || (s % 2 != 0);
            5: return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
            4: return (imm % 4096) != 0;
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard: compare delivered words against the queue, then enqueue newly accepted ones.
    always @(negedge w_clk) begin
        exp_t e;
        if (!w_rst_n) begin
            expQ.delete();
            modelAddr = BASE;
            modelErrCnt = 0;
        end else begin
            checkOutput("err_cnt", {24'h0, err_cnt}, 32'(modelErrCnt));
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_word", 32'(expQ.size()), 32'd1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_inst", out_inst, e.inst);
                    checkOutput("sb_addr", out_addr, e.addr);
                    checkOutput("sb_err", {31'h0, out_err}, {31'h0, e.err});
                    if (e.err && modelErrCnt < 255) modelErrCnt++;
                end
            end
            if (in_valid && in_ready) begin
                e.inst = modelEncode(32'(in_type), 32'(in_opcode5), 32'(in_rd), 32'(in_rs1),
                                     32'(in_rs2), 32'(in_funct3), 32'(in_funct7), in_imm);
                e.addr = modelAddr;
                e.err  = modelErr(int'(in_type), in_opcode5, in_imm);
                expQ.push_back(e);
                modelAddr = modelAddr + 32'd4;
            end
        end
    end

    task automatic setFields(input int t, input logic [4:0] op5, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm);
        in_type    = 3'(t);
        in_opcode5 = op5;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_funct3  = f3;
        in_funct7  = f7;
        in_imm     = imm;
        in_valid   = 1'b1;
    endtask

    task automatic waitAccept(input bit rnd);
        for (int n = 0; n < 100; n++) begin
            @(negedge w_clk);
            if (in_ready) begin
                @(posedge w_clk);
                #1;
                return;
            end
            @(posedge w_clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
        checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input int t, input logic [4:0] op5, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm, input bit rnd);
        setFields(t, op5, rd, rs1, rs2, f3, f7, imm);
        waitAccept(rnd);
    endtask

    function automatic logic [31:0] randImm(input int t);
        int edges[4];
        case (t)
            1, 2: edges = '{-2048, 2047, -2049, 2048};
            3: edges = '{-4096, 4094, -4098, 4096};
            5: edges = '{-1048576, 1048574, -1048578, 1048576};
            4: edges = '{32'h7FFFF000, 1, 32'h80000000, 32'h00000800};
            default: edges = '{0, 1, -1, 2047};
        endcase
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'(edges[$urandom_range(0, 3)]);
            default: begin
                case (t)
                    1, 2: return 32'(int'($urandom_range(0, 4095)) - 2048);
                    3: return 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
                    5: return 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
                    4: return $urandom & 32'hFFFFF000;
                    default: return $urandom;
                endcase
            end
        endcase
    endfunction

    function automatic logic [4:0] randOp(input int t);
        logic [4:0] iops[5];
        iops = '{5'b00100, 5'b00000, 5'b11001, 5'b11100, 5'b00011};
        if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
        case (t)
            0: return 5'b01100;
            2: return 5'b01000;
            3: return 5'b11000;
            4: return ($urandom_range(0, 1) != 0) ? 5'b00101 : 5'b01101;
            5: return 5'b11011;
            default: return iops[$urandom_range(0, 4)];
        endcase
    endfunction

    initial begin
        int t;
        repeat (3) @(posedge w_clk);
        #1;
        checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_inst", out_inst, 32'h0);
        checkOutput("rst_addr", out_addr, 32'h0);
        checkOutput("rst_err", {31'h0, out_err}, 32'h0);
        checkOutput("rst_errcnt", {24'h0, err_cnt}, 32'h0);
        w_rst_n = 1'b1;
        checkOutput("rst_inready", {31'h0, in_ready}, 32'h1);

        applyStimulus(1, 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        checkOutput("addi_inst", out_inst, 32'h00500093);
        checkOutput("addi_addr", out_addr, 32'h0);
        checkOutput("addi_valid", {31'h0, out_valid}, 32'h1);
        checkOutput("addi_err", {31'h0, out_err}, 32'h0);
        applyStimulus(0, 5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        checkOutput("add_inst", out_inst, 32'h002081B3);
        checkOutput("add_addr", out_addr, 32'h4);
        applyStimulus(2, 5'b01000, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
        checkOutput("sw_inst", out_inst, 32'h0020A423);
        checkOutput("sw_addr", out_addr, 32'h8);
        applyStimulus(3, 5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1'b0);
        checkOutput("beq_inst", out_inst, 32'hFE208EE3);
        checkOutput("beq_err", {31'h0, out_err}, 32'h0);
        applyStimulus(5, 5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0);
        checkOutput("jal_inst", out_inst, 32'h008000EF);
        applyStimulus(4, 5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0);
        checkOutput("lui_inst", out_inst, 32'h123452B7);
        checkOutput("lui_err", {31'h0, out_err}, 32'h0);

        applyStimulus(3, 5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0);
        checkOutput("err_bodd", {31'h0, out_err}, 32'h1);
        applyStimulus(1, 5'b01100, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        checkOutput("err_class", {31'h0, out_err}, 32'h1);
        applyStimulus(1, 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
        checkOutput("err_irange", {31'h0, out_err}, 32'h1);
        in_valid = 1'b0;
        @(posedge w_clk);
        #1;
        checkOutput("errcnt_3", {24'h0, err_cnt}, 32'd3);

        // Backpressure: fill the output, then hold out_ready low with a word waiting.
        out_ready = 1'b0;
        applyStimulus(1, 5'b00100, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0);
        setFields(1, 5'b00100, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge w_clk);
            checkOutput("bp_inready", {31'h0, in_ready}, 32'h0);
            checkOutput("bp_inst", out_inst, 32'h00700113);
            checkOutput("bp_addr", out_addr, 32'h24);
        end
        @(posedge w_clk);
        #1;
        out_ready = 1'b1;
        waitAccept(1'b0);
        checkOutput("bp_next_inst", out_inst, 32'h00900193);
        checkOutput("bp_next_addr", out_addr, 32'h28);

        // Asynchronous reset while a word is held.
        in_valid = 1'b0;
        @(posedge w_clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(1, 5'b00100, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        in_valid = 1'b0;
        #3;
        w_rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("arst_inst", out_inst, 32'h0);
        checkOutput("arst_errcnt", {24'h0, err_cnt}, 32'h0);
        repeat (2) @(posedge w_clk);
        #1;
        w_rst_n = 1'b1;
        out_ready = 1'b1;
        applyStimulus(0, 5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        checkOutput("post_rst_addr", out_addr, BASE);
        checkOutput("post_rst_inst", out_inst, 32'h002081B3);

        // Randomized stream with random backpressure, checked by the scoreboard.
        for (int i = 0; i < 300; i++) begin
            t = ($urandom_range(0, 19) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus(t, randOp(t), 5'($urandom), 5'($urandom), 5'($urandom),
                          3'($urandom), 7'($urandom), randImm(t), 1'b1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge w_clk);
        #1;

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(6, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                          3'($urandom), 7'($urandom), $urandom, 1'b0);
        end
        in_valid = 1'b0;
        repeat (3) @(posedge w_clk);
        #1;
        checkOutput("errcnt_sat", {24'h0, err_cnt}, 32'd255);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
